// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame/divisor widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

   localparam int UART_WIDTH     = 8;
   localparam int UART_DIV_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: loadable down-counter that pulses bit_end on the last clock of each bit.
// Latency: bit_end is combinational from the count; a period is div+1 clocks from load or reload.
// Backpressure: none; the counter holds its value whenever run is low.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int DIV_WIDTH = UART_DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 run,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 bit_end
);

   logic [DIV_WIDTH-1:0] cnt;

   assign bit_end = run && (cnt == '0);

   // Count down each clock while a frame runs; reload at the end of every bit period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= div;
      end else if (run) begin
         if (cnt == '0) begin
            cnt <= div;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that pops one word per frame from a FIFO and serialises it LSB-first.
// Latency: start bit on txd the clock after the pop decision; frame = (WIDTH+2)*(baud_div+1) clocks.
// Backpressure: a new frame starts only when en=1 and the FIFO is non-empty; frames in flight always finish.
module uart_tx_drain
   import uart_pkg::*;
#(
   parameter int WIDTH     = UART_WIDTH,
   parameter int DIV_WIDTH = UART_DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [DIV_WIDTH-1:0] baud_div,
   input  logic                 fifo_empty,
   input  logic [WIDTH-1:0]     fifo_dout,
   output logic                 fifo_rd,
   output logic                 txd,
   output logic                 busy,
   output logic                 done
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   tx_state_t            state_q, state_nx;
   logic [WIDTH-1:0]     shift_q, shift_nx;
   logic [IDX_W-1:0]     idx_q, idx_nx;
   logic [DIV_WIDTH-1:0] bit_len_q;
   logic                 txd_nx, rd_nx, done_nx;
   logic                 start_frame;
   logic                 bit_end;
   logic [DIV_WIDTH-1:0] tick_div;

   // The only point where the FIFO head and the divisor are sampled.
   assign start_frame = (state_q == IDLE) && en && !fifo_empty;

   // First period uses the live divisor (being latched this edge); reloads use the latched copy.
   assign tick_div = start_frame ? baud_div : bit_len_q;

   uart_baud_tick #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_baud_tick (
      .clk     (clk),
      .reset   (reset),
      .load    (start_frame),
      .run     (state_q != IDLE),
      .div     (tick_div),
      .bit_end (bit_end)
   );

   // Next-state, shift and output decode; txd follows the state being entered.
   always_comb begin
      state_nx = state_q;
      shift_nx = shift_q;
      idx_nx   = idx_q;
      rd_nx    = 1'b0;
      done_nx  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_frame) begin
               shift_nx = fifo_dout;
               idx_nx   = '0;
               rd_nx    = 1'b1;
               state_nx = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_nx = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_nx = shift_q >> 1;
               if (idx_q == LAST_IDX) begin
                  idx_nx   = '0;
                  state_nx = STOP;
               end else begin
                  idx_nx = idx_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               done_nx  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (state_nx == START) begin
         txd_nx = 1'b0;
      end else if (state_nx == DATA) begin
         txd_nx = shift_nx[0];
      end else begin
         txd_nx = 1'b1;
      end
   end

   // State, datapath and registered outputs; reset forces the idle line immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         idx_q     <= '0;
         bit_len_q <= '0;
         txd       <= 1'b1;
         fifo_rd   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q <= state_nx;
         shift_q <= shift_nx;
         idx_q   <= idx_nx;
         if (start_frame) begin
            bit_len_q <= baud_div;
         end
         txd     <= txd_nx;
         fifo_rd <= rd_nx;
         busy    <= (state_nx != IDLE);
         done    <= done_nx;
      end
   end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with a queue-backed FIFO model.
// Latency: n/a.
// Backpressure: FIFO pops on each sampled fifo_rd clock.
module tb_uart_tx_drain;

   logic        clk;
   logic        reset;
   logic        en;
   logic [15:0] baud_div;
   logic        fifo_empty;
   logic [7:0]  fifo_dout;
   logic        fifo_rd;
   logic        txd;
   logic        busy;
   logic        done;

   logic [7:0]  fq[$];
   int          rd_cnt;
   int          n_assert;
   int          n_fail;

   uart_tx_drain #(
      .WIDTH     (8),
      .DIV_WIDTH (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .baud_div   (baud_div),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd    (fifo_rd),
      .txd        (txd),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      fifo_empty = (fq.size() == 0);
      fifo_dout  = (fq.size() == 0) ? 8'h00 : fq[0];
   endtask

   task automatic push(input logic [7:0] b);
      fq.push_back(b);
      refresh();
   endtask

   // Advance to the next falling edge; a sampled fifo_rd pops the model FIFO.
   task automatic step();
      @(negedge clk);
      if (fifo_rd === 1'b1) begin
         rd_cnt++;
         if (fq.size() > 0) void'(fq.pop_front());
         refresh();
      end
   endtask

   // Check one whole frame, starting with the first start-bit clock.
   // ev_kind 1 drops en, 2 changes baud_div to 7, on clock 1 of frame bit ev_bit.
   task automatic expect_frame(input string tag, input logic [7:0] data, input int cpb,
                               input int ev_bit, input int ev_kind);
      logic exp_txd;
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < cpb; c++) begin
            if (b == ev_bit && c == 1) begin
               if (ev_kind == 1) en = 1'b0;
               if (ev_kind == 2) baud_div = 16'd7;
            end
            step();
            exp_txd = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : data[b-1];
            chk($sformatf("%s txd bit%0d clk%0d", tag, b, c), 32'(txd), 32'(exp_txd));
            chk($sformatf("%s fifo_rd bit%0d clk%0d", tag, b, c), 32'(fifo_rd),
                32'((b == 0 && c == 0) ? 1 : 0));
            chk($sformatf("%s busy bit%0d clk%0d", tag, b, c), 32'(busy), 32'd1);
         end
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rd_cnt   = 0;
      reset    = 1'b1;
      en       = 1'b0;
      baud_div = 16'd3;
      refresh();

      // Reset state
      step();
      step();
      chk("reset txd", 32'(txd), 32'd1);
      chk("reset fifo_rd", 32'(fifo_rd), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);

      // Single frame 0xA5, 4 clocks per bit
      reset = 1'b0;
      en    = 1'b1;
      push(8'hA5);
      expect_frame("single", 8'hA5, 4, -1, 0);
      step();
      chk("single done", 32'(done), 32'd1);
      chk("single idle txd", 32'(txd), 32'd1);
      chk("single idle busy", 32'(busy), 32'd0);
      step();
      chk("single done width", 32'(done), 32'd0);
      chk("single rd count", 32'(rd_cnt), 32'd1);

      // Back-to-back 0x00, 0xFF at 1 clock per bit
      baud_div = 16'd0;
      push(8'h00);
      push(8'hFF);
      expect_frame("b2b f0", 8'h00, 1, -1, 0);
      step();
      chk("b2b gap txd", 32'(txd), 32'd1);
      chk("b2b gap done", 32'(done), 32'd1);
      chk("b2b gap fifo_rd", 32'(fifo_rd), 32'd0);
      expect_frame("b2b f1", 8'hFF, 1, -1, 0);
      step();
      chk("b2b done", 32'(done), 32'd1);
      chk("b2b rd count", 32'(rd_cnt), 32'd3);

      // Empty FIFO with en high
      baud_div = 16'd3;
      for (int i = 0; i < 100; i++) begin
         step();
         chk($sformatf("empty idle c%0d", i), 32'({fifo_rd, txd, busy}), 32'b010);
      end

      // en dropped during data bit 3 of 0x3C with a second word queued
      push(8'h3C);
      push(8'h55);
      expect_frame("engate", 8'h3C, 4, 4, 1);
      step();
      chk("engate done", 32'(done), 32'd1);
      for (int i = 0; i < 20; i++) begin
         step();
         chk($sformatf("engate hold c%0d", i), 32'({fifo_rd, txd, busy}), 32'b010);
      end
      chk("engate rd count", 32'(rd_cnt), 32'd4);
      chk("engate fifo level", 32'(fq.size()), 32'd1);

      // Reset during data bit 5 of 0x55
      en = 1'b1;
      repeat (26) step();
      chk("midrst pre txd", 32'(txd), 32'd0);
      chk("midrst pre busy", 32'(busy), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("midrst txd", 32'(txd), 32'd1);
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst fifo_rd", 32'(fifo_rd), 32'd0);
      push(8'h96);
      step();
      step();
      chk("midrst rd count", 32'(rd_cnt), 32'd5);
      reset = 1'b0;
      expect_frame("postrst", 8'h96, 4, -1, 0);
      step();
      chk("postrst done", 32'(done), 32'd1);
      chk("postrst rd count", 32'(rd_cnt), 32'd6);

      // Divisor change 3 -> 7 during frame 1
      push(8'h11);
      push(8'h22);
      expect_frame("div f1", 8'h11, 4, 5, 2);
      step();
      chk("div f1 done", 32'(done), 32'd1);
      chk("div gap txd", 32'(txd), 32'd1);
      expect_frame("div f2", 8'h22, 8, -1, 0);
      step();
      chk("div f2 done", 32'(done), 32'd1);
      chk("div rd count", 32'(rd_cnt), 32'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per frame and the FIFO word width.
REQ-002 SHALL have parameter DIV_WIDTH, default 16: width of the baud divisor.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: transmit enable; gates only the start of new frames.
REQ-006 SHALL have port baud_div, input, DIV_WIDTH bits: clocks per bit minus 1.
REQ-007 SHALL have port fifo_empty, input, 1 bit: source FIFO holds no data.
REQ-008 SHALL have port fifo_dout, input, WIDTH bits: FIFO head word, valid combinationally while fifo_empty=0.
REQ-009 SHALL have port fifo_rd, output, 1 bit: pop strobe; the FIFO advances on its falling edge.
REQ-010 SHALL have port txd, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-clock pulse at the end of each frame.

Function
REQ-013 SHALL implement the FSM states IDLE, START, DATA and STOP.
REQ-014 IDLE SHALL, at a rising edge with en=1 and fifo_empty=0, perform all of the following in that edge:
- latch fifo_dout into the shift register;
- latch baud_div into the bit-length register;
- set fifo_rd=1 and txd=0;
- reset the bit-timer and bit index;
- go to START.
REQ-015 fifo_rd SHALL be high for exactly one clock per frame (registered), so each frame pops exactly one word.
REQ-016 Each bit period SHALL last latched baud_div+1 clocks; baud_div=0 gives 1 clock per bit.
REQ-017 START SHALL drive txd=0 for one bit period, then go to DATA.
REQ-018 DATA SHALL drive WIDTH bits LSB-first, one bit period each, then go to STOP.
REQ-019 STOP SHALL drive txd=1 for one bit period, then go to IDLE and pulse done=1 for one clock.
REQ-020 The frame length SHALL be (WIDTH+2)*(baud_div+1) clocks, measured from the first txd=0 clock to the last stop-bit clock.
REQ-021 After each frame, IDLE SHALL occupy at least one clock before the next start bit.
- Back-to-back frames therefore have exactly one extra idle-high clock between them.
REQ-022 Changes to baud_div mid-frame SHALL have no effect until the next frame.
REQ-023 Deasserting en mid-frame SHALL NOT abort the frame; it only blocks the next one.
REQ-024 With fifo_empty=1, the block SHALL stay in IDLE with fifo_rd=0 and txd=1.
REQ-025 fifo_dout SHALL NOT be sampled at any time other than the IDLE-to-START edge.
REQ-026 The bit-timer and bit index SHALL be sized to never overflow:
- bit-timer: DIV_WIDTH bits;
- bit index: clog2(WIDTH) bits, wrapping only by explicit reset in the FSM.

Reset
REQ-027 Asserting reset SHALL immediately force all of the following, independent of clk:
- state=IDLE, txd=1, fifo_rd=0, busy=0, done=0;
- shift register, bit-timer and bit index = 0.
REQ-028 Reset mid-frame SHALL abandon the frame without issuing another fifo_rd.
- The word already popped is lost.
REQ-029 After reset is released, the first frame SHALL start no earlier than the first rising edge at which en=1 and fifo_empty=0.

Structure
REQ-030 A shared package uart_pkg SHALL hold the FSM state encoding constants (2-bit IDLE/START/DATA/STOP) and the default WIDTH and DIV_WIDTH.
REQ-031 The block SHALL contain one sub-module, uart_baud_tick.
- It holds the loadable down-counter, reloaded from the latched divisor, that emits a one-clock bit_end pulse.
REQ-032 The FSM, shift register and output registers SHALL reside in uart_tx_drain.
- All outputs SHALL be registered.

Verification
REQ-033 Single frame: baud_div=3, en=1, FIFO holds 0xA5 -> all of the following:
- txd = 0,1,0,1,0,0,1,0,1,1 with each level held 4 clocks (40 clocks total);
- exactly one fifo_rd pulse;
- done pulses on the clock after the stop bit.
REQ-034 Back-to-back: FIFO holds 0x00,0xFF, baud_div=0 -> all of the following:
- txd = 0,0,0,0,0,0,0,0,0,1,1 (one idle clock), then 0,1,1,1,1,1,1,1,1,1;
- two fifo_rd pulses.
REQ-035 Empty FIFO: en=1, fifo_empty=1 for 100 clocks -> fifo_rd never asserts, txd=1, busy=0.
REQ-036 en gating: en drops during bit 3 of a 0x3C frame with 2 words queued -> the frame completes intact and no second fifo_rd occurs.
REQ-037 Reset mid-frame: reset asserted during DATA bit 5 -> all of the following:
- txd=1 and busy=0 the same cycle, without a clk edge;
- after release with the FIFO non-empty, the next frame starts with one new fifo_rd.
REQ-038 Divisor change: baud_div changed from 3 to 7 during frame 1 -> frame 1 keeps 4 clocks per bit and frame 2 uses 8 clocks per bit.
